// File: rtl/counter_sequencer.sv
// Button front end for the starter-kit counter: three debounced push-buttons drive a
// small FSM that emits count-enable and synchronous-clear pulses (free-run, step, zero).
module counter_sequencer #(
  parameter int CLK_DIV      = 1000000,
  parameter int DEBOUNCE_CYC = 16,
  parameter int DIV_W        = 24,
  parameter int DB_W         = 8
) (
  input  logic       clock_i,
  input  logic       clear_i,
  input  logic       start_stop_i,
  input  logic       step_i,
  input  logic       zero_i,
  output logic       count_o,
  output logic       clear_o,
  output logic       running_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    CLR  = 2'b11
  } state_t;

  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  // Button index: 0 = step, 1 = start/stop, 2 = zero.
  logic [2:0]      raw;
  logic [2:0]      s1;
  logic [2:0]      s2;
  logic [2:0]      db_level;
  logic [2:0]      ev;
  logic [DB_W-1:0] db_cnt [3];

  assign raw = {zero_i, start_stop_i, step_i};

  for (genvar gi = 0; gi < 3; gi++) begin : g_button
    always_ff @(posedge clock_i or posedge clear_i) begin
      if (clear_i) begin
        s1[gi]       <= 1'b0;
        s2[gi]       <= 1'b0;
        db_level[gi] <= 1'b0;
        db_cnt[gi]   <= '0;
        ev[gi]       <= 1'b0;
      end else begin
        s1[gi] <= raw[gi];
        s2[gi] <= s1[gi];
        ev[gi] <= 1'b0;
        if (s2[gi] != db_level[gi]) begin
          if (db_cnt[gi] == DB_MAX) begin
            db_level[gi] <= s2[gi];
            db_cnt[gi]   <= '0;
            // Only the rising edge of the accepted level is an event.
            ev[gi]       <= s2[gi];
          end else begin
            db_cnt[gi] <= db_cnt[gi] + 1'b1;
          end
        end else begin
          db_cnt[gi] <= '0;
        end
      end
    end
  end

  logic              step_ev;
  logic              ss_ev;
  logic              zero_ev;
  state_t            state;
  state_t            ret;
  logic [DIV_W-1:0]  div_cnt;

  assign step_ev = ev[0];
  assign ss_ev   = ev[1];
  assign zero_ev = ev[2];
  assign state_o = state;

  // Outputs are registered from the next state, so they line up with state_o.
  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      state     <= IDLE;
      ret       <= IDLE;
      div_cnt   <= '0;
      count_o   <= 1'b0;
      clear_o   <= 1'b0;
      running_o <= 1'b0;
    end else begin
      count_o <= 1'b0;
      clear_o <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (zero_ev) begin
            state   <= CLR;
            ret     <= IDLE;
            clear_o <= 1'b1;
          end else if (ss_ev) begin
            state     <= RUN;
            running_o <= 1'b1;
          end else if (step_ev) begin
            state   <= STEP;
            count_o <= 1'b1;
          end
        end
        RUN: begin
          if (zero_ev) begin
            state     <= CLR;
            ret       <= RUN;
            clear_o   <= 1'b1;
            running_o <= 1'b0;
            div_cnt   <= '0;
          end else if (ss_ev) begin
            // A tick landing on this edge is dropped along with RUN.
            state     <= IDLE;
            running_o <= 1'b0;
            div_cnt   <= '0;
          end else if (div_cnt == DIV_MAX) begin
            div_cnt <= '0;
            count_o <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        STEP: begin
          state   <= IDLE;
          div_cnt <= '0;
        end
        CLR: begin
          state     <= ret;
          running_o <= (ret == RUN);
          div_cnt   <= '0;
        end
        default: begin
          state   <= IDLE;
          div_cnt <= '0;
        end
      endcase
    end
  end

endmodule
